// File: rtl/box_move_ctrl.sv
// Frame-paced move-command sequencer for the two-box pixel generator:
// first move, repeat delay, auto-repeat and an idle-triggered demo walk.
module box_move_ctrl #(
  parameter int REPEAT_DLY   = 15,
  parameter int IDLE_TIMEOUT = 600,
  parameter int AUTO_STEP    = 64
) (
  input  logic       rfr_clk,
  input  logic       reset,
  input  logic       v_sync,
  input  logic [3:0] btn_dir,
  input  logic       sel_box1,
  input  logic       sel_box2,
  input  logic       speed_sw,
  input  logic       demo_en,
  output logic       move_box1,
  output logic       move_box2,
  output logic [4:0] move_dir,
  output logic       speed,
  output logic [1:0] mode
);

  localparam int RW = $clog2(REPEAT_DLY) + 1;
  localparam logic [RW-1:0] RPT_LAST  = RW'(REPEAT_DLY - 1);
  localparam logic [9:0]    IDLE_LAST = 10'(IDLE_TIMEOUT - 1);
  localparam logic [5:0]    STEP_LAST = 6'(AUTO_STEP - 1);

  localparam logic [3:0] D_RIGHT = 4'b0001;
  localparam logic [3:0] D_UP    = 4'b0010;
  localparam logic [3:0] D_DOWN  = 4'b0100;
  localparam logic [3:0] D_LEFT  = 4'b1000;

  typedef enum logic [2:0] {
    IDLE,
    FIRST,
    WAIT,
    REPEAT,
    AUTO
  } state_t;

  state_t        state, state_n;
  logic          v_sync_d;
  logic          frame_tick;
  logic [3:0]    cur_dir, cur_dir_n;
  logic [RW-1:0] rpt_cnt, rpt_cnt_n;
  logic [9:0]    idle_cnt, idle_cnt_n;
  logic [5:0]    step_cnt, step_cnt_n;
  logic [3:0]    enc;
  logic          pressed;
  logic          b1_n, b2_n, spd_n;
  logic [3:0]    dir_n;
  logic [1:0]    mode_n;

  assign frame_tick = v_sync & ~v_sync_d;
  assign pressed    = |btn_dir;

  function automatic logic [3:0] next_auto(input logic [3:0] d);
    logic [3:0] r;
    unique case (d)
      D_RIGHT: r = D_DOWN;
      D_DOWN:  r = D_LEFT;
      D_LEFT:  r = D_UP;
      default: r = D_RIGHT;
    endcase
    return r;
  endfunction

  always_comb begin
    enc = 4'b0000;
    priority case (1'b1)
      btn_dir[0]: enc = D_RIGHT;
      btn_dir[3]: enc = D_LEFT;
      btn_dir[2]: enc = D_DOWN;
      btn_dir[1]: enc = D_UP;
      default:    enc = 4'b0000;
    endcase
  end

  // Next state and counters, evaluated as if this cycle were a frame tick.
  always_comb begin
    state_n    = state;
    cur_dir_n  = cur_dir;
    rpt_cnt_n  = rpt_cnt;
    step_cnt_n = 6'd0;
    unique case (state)
      IDLE: begin
        if (pressed) begin
          state_n = FIRST;
        end else if (demo_en && idle_cnt >= IDLE_LAST) begin
          state_n   = AUTO;
          cur_dir_n = D_RIGHT;
        end
      end
      FIRST, WAIT, REPEAT: begin
        if (!pressed) begin
          state_n = IDLE;
        end else if (enc != cur_dir) begin
          state_n = FIRST;
        end else if (state == FIRST) begin
          state_n   = WAIT;
          rpt_cnt_n = '0;
        end else if (state == WAIT) begin
          if (rpt_cnt == RPT_LAST) begin
            state_n   = REPEAT;
            rpt_cnt_n = '0;
          end else begin
            rpt_cnt_n = rpt_cnt + 1'b1;
          end
        end
      end
      AUTO: begin
        if (pressed) begin
          state_n = FIRST;
        end else if (!demo_en) begin
          state_n = IDLE;
        end else if (step_cnt == STEP_LAST) begin
          cur_dir_n = next_auto(cur_dir);
        end else begin
          step_cnt_n = step_cnt + 6'd1;
        end
      end
      default: state_n = IDLE;
    endcase
    if (state_n == FIRST)
      cur_dir_n = enc;
    if (state == IDLE && state_n == IDLE)
      idle_cnt_n = (idle_cnt == 10'h3ff) ? idle_cnt : idle_cnt + 10'd1;
    else
      idle_cnt_n = 10'd0;
  end

  always_comb begin
    b1_n   = 1'b0;
    b2_n   = 1'b0;
    spd_n  = 1'b0;
    dir_n  = 4'b0000;
    mode_n = 2'd1;
    unique case (state_n)
      IDLE: mode_n = 2'd0;
      FIRST, REPEAT: begin
        b1_n  = sel_box1;
        b2_n  = sel_box2;
        spd_n = speed_sw;
        dir_n = enc;
      end
      AUTO: begin
        b1_n   = 1'b1;
        b2_n   = 1'b1;
        dir_n  = cur_dir_n;
        mode_n = 2'd2;
      end
      default: mode_n = 2'd1;
    endcase
  end

  always_ff @(posedge rfr_clk or posedge reset) begin
    if (reset) begin
      v_sync_d  <= 1'b0;
      state     <= IDLE;
      cur_dir   <= 4'b0000;
      rpt_cnt   <= '0;
      idle_cnt  <= 10'd0;
      step_cnt  <= 6'd0;
      move_box1 <= 1'b0;
      move_box2 <= 1'b0;
      move_dir  <= 5'b00000;
      speed     <= 1'b0;
      mode      <= 2'd0;
    end else begin
      v_sync_d <= v_sync;
      if (frame_tick) begin
        state     <= state_n;
        cur_dir   <= cur_dir_n;
        rpt_cnt   <= rpt_cnt_n;
        idle_cnt  <= idle_cnt_n;
        step_cnt  <= step_cnt_n;
        move_box1 <= b1_n;
        move_box2 <= b2_n;
        move_dir  <= {1'b0, dir_n};
        speed     <= spd_n;
        mode      <= mode_n;
      end
    end
  end

endmodule

// File: tb/tb_box_move_ctrl.sv
// Directed bench for box_move_ctrl with short repeat/idle/demo timings.
module tb_box_move_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       v_sync = 1'b0;
  logic [3:0] btn_dir = 4'b0;
  logic       sel_box1 = 1'b0;
  logic       sel_box2 = 1'b0;
  logic       speed_sw = 1'b0;
  logic       demo_en = 1'b0;
  logic       move_box1, move_box2, speed;
  logic [4:0] move_dir;
  logic [1:0] mode;
  logic [9:0] obs;
  int         total = 0;
  int         bad = 0;
  logic [4:0] dirs [4];

  box_move_ctrl #(
    .REPEAT_DLY(4),
    .IDLE_TIMEOUT(8),
    .AUTO_STEP(4)
  ) dut (
    .rfr_clk(clk),
    .reset(reset),
    .v_sync(v_sync),
    .btn_dir(btn_dir),
    .sel_box1(sel_box1),
    .sel_box2(sel_box2),
    .speed_sw(speed_sw),
    .demo_en(demo_en),
    .move_box1(move_box1),
    .move_box2(move_box2),
    .move_dir(move_dir),
    .speed(speed),
    .mode(mode)
  );

  always #5 clk = ~clk;

  assign obs = {mode, speed, move_dir, move_box2, move_box1};

  function automatic logic [9:0] ex(input logic [1:0] m, input logic s,
                                    input logic [4:0] d, input logic b2,
                                    input logic b1);
    return {m, s, d, b2, b1};
  endfunction

  task automatic chk(input string tag, input logic [9:0] e);
    total++;
    assert (obs === e) else begin
      bad++;
      $error("FAIL %s obs=%b exp=%b", tag, obs, e);
    end
  endtask

  task automatic frame();
    @(negedge clk) v_sync = 1'b1;
    repeat (10) @(negedge clk);
    v_sync = 1'b0;
    repeat (90) @(negedge clk);
  endtask

  initial begin
    dirs[0] = 5'b00001;
    dirs[1] = 5'b00100;
    dirs[2] = 5'b01000;
    dirs[3] = 5'b00010;

    repeat (3) @(negedge clk);
    chk("reset", ex(0, 0, 0, 0, 0));
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // first move, repeat delay, auto-repeat
    sel_box1 = 1'b1;
    btn_dir  = 4'b0001;
    frame();
    chk("rpt_f1", ex(1, 0, 5'b00001, 0, 1));
    for (int i = 2; i <= 5; i++) begin
      frame();
      chk($sformatf("rpt_wait_f%0d", i), ex(1, 0, 0, 0, 0));
    end
    for (int i = 6; i <= 10; i++) begin
      frame();
      chk($sformatf("rpt_move_f%0d", i), ex(1, 0, 5'b00001, 0, 1));
    end

    // reset in REPEAT
    @(negedge clk) reset = 1'b1;
    #1 chk("rst_async", ex(0, 0, 0, 0, 0));
    repeat (5) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("rst_hold", ex(0, 0, 0, 0, 0));
    frame();
    chk("rst_first", ex(1, 0, 5'b00001, 0, 1));
    btn_dir = 4'b0000;
    frame();
    chk("release", ex(0, 0, 0, 0, 0));

    // priority and direction change in WAIT
    sel_box2 = 1'b1;
    speed_sw = 1'b1;
    btn_dir  = 4'b1001;
    frame();
    chk("prio_right", ex(1, 1, 5'b00001, 1, 1));
    frame();
    chk("prio_wait", ex(1, 0, 0, 0, 0));
    btn_dir = 4'b1000;
    frame();
    chk("chg_left", ex(1, 1, 5'b01000, 1, 1));
    btn_dir = 4'b0000;
    frame();
    chk("chg_rel", ex(0, 0, 0, 0, 0));

    // no box selected still advances
    sel_box1 = 1'b0;
    sel_box2 = 1'b0;
    speed_sw = 1'b0;
    btn_dir  = 4'b0010;
    frame();
    chk("nosel_first", ex(1, 0, 5'b00010, 0, 0));
    frame();
    chk("nosel_wait", ex(1, 0, 0, 0, 0));
    btn_dir = 4'b0000;
    frame();
    chk("nosel_rel", ex(0, 0, 0, 0, 0));

    // idle timeout into demo walk
    demo_en = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      frame();
      chk($sformatf("idle_f%0d", i), ex(0, 0, 0, 0, 0));
    end
    for (int i = 0; i < 16; i++) begin
      frame();
      chk($sformatf("auto_%0d", i), ex(2, 0, dirs[i/4], 1, 1));
    end
    frame();
    chk("auto_wrap", ex(2, 0, 5'b00001, 1, 1));

    // button beats demo_en drop
    btn_dir  = 4'b0100;
    demo_en  = 1'b0;
    sel_box1 = 1'b1;
    speed_sw = 1'b1;
    frame();
    chk("auto_btn", ex(1, 1, 5'b00100, 0, 1));
    btn_dir  = 4'b0000;
    speed_sw = 1'b0;
    frame();
    chk("auto_btn_rel", ex(0, 0, 0, 0, 0));

    // demo_en drop exits to IDLE
    demo_en = 1'b1;
    repeat (8) frame();
    chk("auto_again", ex(2, 0, 5'b00001, 1, 1));
    demo_en = 1'b0;
    frame();
    chk("auto_exit", ex(0, 0, 0, 0, 0));
    frame();
    chk("idle_stay", ex(0, 0, 0, 0, 0));

    // long v_sync high yields a single tick
    btn_dir = 4'b0001;
    @(negedge clk) v_sync = 1'b1;
    repeat (300) @(negedge clk);
    chk("long_vs", ex(1, 0, 5'b00001, 0, 1));
    v_sync = 1'b0;
    repeat (90) @(negedge clk);
    chk("long_vs_hold", ex(1, 0, 5'b00001, 0, 1));
    frame();
    chk("long_vs_next", ex(1, 0, 0, 0, 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/box_move_ctrl.md
BOX_MOVE_CTRL -- requirements
Module: box_move_ctrl

Interface
REQ-001 The block SHALL have parameter REPEAT_DLY, default 15: frames a held button waits after its first move before auto-repeat starts.
REQ-002 The block SHALL have parameter IDLE_TIMEOUT, default 600: idle frames before demo mode.
REQ-003 The block SHALL have parameter AUTO_STEP, default 64: frames per direction leg in demo mode.
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset; it is the only sequential driver of the pixel generator's move-command inputs. The ports SHALL be:
- rfr_clk, in, 1: the single clock.
- reset, in, 1: asynchronous, active-high.
- v_sync, in, 1: frame sync, synchronous to rfr_clk.
- btn_dir, in, 4: debounced, active-high; [3] left, [2] down, [1] up, [0] right.
- sel_box1, in, 1: box 1 selected for manual moves.
- sel_box2, in, 1: box 2 selected for manual moves.
- speed_sw, in, 1: fast-move request.
- demo_en, in, 1: demo mode allowed.
- move_box1, out, 1: move box 1 this frame.
- move_box2, out, 1: move box 2 this frame.
- move_dir, out, 5: one-hot direction; [3] left, [2] down, [1] up, [0] right; [4] always 0.
- speed, out, 1: fast move.
- mode, out, 2: 0 manual-idle, 1 manual-active, 2 demo.

Function
REQ-005 The block SHALL derive frame_tick from the registered previous value of v_sync: frame_tick = v_sync & ~v_sync_d, lasting one rfr_clk cycle.
REQ-006 All outputs, the state and all counters SHALL change only in the cycle after frame_tick; between ticks they SHALL hold their values.
REQ-007 Direction encoding SHALL use priority right > left > down > up when several btn_dir bits are set; exactly one move_dir bit is set during a move, and move_dir is all zeros otherwise.
REQ-008 The state machine SHALL have states IDLE, FIRST, WAIT, REPEAT and AUTO; the state SHALL be evaluated only at frame_tick.
REQ-009 IDLE: btn_dir == 0 holds the state; any btn_dir bit set moves to FIRST.
REQ-010 FIRST: the outputs SHALL carry one move for exactly one frame, with move_boxN = sel_boxN, speed = speed_sw and the encoded direction.
REQ-011 Leaving FIRST:
- buttons released -> IDLE.
- same encoded direction still held -> WAIT with rpt_cnt = 0.
- different encoded direction -> FIRST again with the new direction.
REQ-012 WAIT: move_box1, move_box2 and move_dir SHALL be 0; rpt_cnt increments each frame.
REQ-013 WAIT transitions: rpt_cnt == REPEAT_DLY-1 -> REPEAT; release -> IDLE; direction change -> FIRST.
REQ-014 REPEAT: the block SHALL issue a move every frame, with sel_boxN, speed_sw and the direction re-sampled at each frame_tick.
REQ-015 REPEAT transitions: release -> IDLE; direction change -> FIRST.
REQ-016 idle_cnt is 10 bits and saturating. It SHALL increment per frame in IDLE and clear on any state other than IDLE.
REQ-017 IDLE -> AUTO SHALL occur when idle_cnt == IDLE_TIMEOUT-1 and demo_en = 1; with demo_en = 0 the counter saturates and the block stays in IDLE.
REQ-018 AUTO outputs:
- move_box1 = move_box2 = 1 every frame.
- speed = 0.
- direction sequence right -> down -> left -> up -> right, advancing every AUTO_STEP frames on a 6-bit saturating-free step counter that wraps at AUTO_STEP-1.
REQ-019 AUTO entry SHALL start at direction right with step count 0.
REQ-020 AUTO exit: any btn_dir bit set at frame_tick -> FIRST, so the same frame carries the manual move; demo_en = 0 -> IDLE with idle_cnt = 0. If both occur together, the button SHALL win.
REQ-021 mode SHALL be 0 in IDLE, 1 in FIRST, WAIT and REPEAT, and 2 in AUTO.
REQ-022 Because the pixel generator samples on posedge v_sync, a command registered after tick N SHALL take effect at frame N+1.
REQ-023 If sel_box1 = sel_box2 = 0 in a manual move state, the state machine SHALL still advance while both move outputs are 0.

Reset
REQ-024 While reset = 1, asynchronously:
- move_box1, move_box2, speed = 0; move_dir = 5'b0; mode = 0.
- state = IDLE.
- rpt_cnt, idle_cnt, step counter and v_sync_d = 0.
REQ-025 Reset asserted mid-operation, including in AUTO or REPEAT, SHALL take effect immediately with no move issued afterwards. After release the first action occurs no earlier than the first frame_tick.

Verification (bench parameters REPEAT_DLY = 4, IDLE_TIMEOUT = 8, AUTO_STEP = 4; v_sync period 100 clocks)
REQ-026 Hold btn_dir = 0001 with sel_box1 = 1 for 10 frames -> move_dir = 00001 and move_box1 = 1 at frame 1; zeros at frames 2-5; move every frame from frame 6 on.
REQ-027 btn_dir = 1001 -> move_dir = 00001 (right wins); then change to 1000 while in WAIT -> FIRST, move_dir = 01000 at the next frame.
REQ-028 No buttons with demo_en = 1 -> mode = 2 after 8 frames; both boxes move right for 4 frames, then down for 4, left for 4, up for 4, with speed = 0.
REQ-029 In AUTO, press btn_dir = 0100 with demo_en dropping in the same frame -> FIRST, mode = 1, move_dir = 00100.
REQ-030 Assert reset during REPEAT -> all outputs 0 within the same cycle; no move before the first frame_tick after release.
REQ-031 Hold v_sync high for 300 clocks -> exactly one frame_tick and one state advance.
